// File: rtl/popcount_pkg.sv
// Shared types and constants for the sequential population counter.
package popcount_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic MODE_ONES  = 1'b0;
  localparam logic MODE_ZEROS = 1'b1;

endpackage

// File: rtl/popcount_shreg.sv
// Loadable right-shift register with zero fill, synchronous clear and zero detect.
module popcount_shreg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             lsb,
  output logic             is_zero
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = d;
    end else if (shift_en) begin
      q_d = q_q >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q       = q_q;
  assign lsb     = q_q[0];
  assign is_zero = (q_q == '0);

endmodule

// File: rtl/popcount_seq.sv
// Sequential ones/zeros counter: loads a word, shifts it LSB-first and stops early
// once the remaining word is zero; result held with a start/busy/done handshake.
module popcount_seq
  import popcount_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] data_in,
  input  logic [CNT_W-1:0] target,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             match
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;

  logic             sreg_load;
  logic             sreg_shift;
  logic [WIDTH-1:0] sreg_load_val;
  logic [WIDTH-1:0] sreg_q;
  logic             sreg_lsb;
  logic             sreg_zero;

  // Zeros are counted by inverting at load time so the datapath only ever counts ones.
  assign sreg_load_val = (mode == MODE_ZEROS) ? ~data_in : data_in;

  popcount_shreg #(
    .WIDTH(WIDTH)
  ) u_shreg (
    .clk     (clk),
    .clr     (rst),
    .load    (sreg_load),
    .shift_en(sreg_shift),
    .d       (sreg_load_val),
    .q       (sreg_q),
    .lsb     (sreg_lsb),
    .is_zero (sreg_zero)
  );

  always_comb begin
    sreg_consistent: assert (sreg_zero == (sreg_q == '0) && sreg_lsb == sreg_q[0]);
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    valid_d    = valid_q;
    sreg_load  = 1'b0;
    sreg_shift = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sreg_load = 1'b1;
          count_d   = '0;
          valid_d   = 1'b0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (sreg_zero) begin
          state_d = DONE;
        end else begin
          sreg_shift = 1'b1;
          count_d    = count_q + {{(CNT_W-1){1'b0}}, sreg_lsb};
        end
      end
      DONE: begin
        done    = 1'b1;
        valid_d = 1'b1;
        // A restart in DONE still pulses done this cycle but invalidates the result.
        if (start) begin
          sreg_load = 1'b1;
          count_d   = '0;
          valid_d   = 1'b0;
          state_d   = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  assign count = count_q;
  assign match = valid_q && (count_q == target);

endmodule

// File: tb/tb_popcount_seq.sv
// Directed self-checking bench for popcount_seq at WIDTH=8.
module tb_popcount_seq;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] data_in;
  logic [CNT_W-1:0] target;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] count;
  logic             match;

  int checks = 0;
  int errors = 0;

  popcount_seq #(
    .WIDTH(WIDTH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mode   (mode),
    .data_in(data_in),
    .target (target),
    .busy   (busy),
    .done   (done),
    .count  (count),
    .match  (match)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Present a start at the next falling edge; returns #1 after the sampling edge E0.
  task automatic launch(input logic [WIDTH-1:0] d, input logic m, input logic hold);
    @(negedge clk);
    data_in = d;
    mode    = m;
    start   = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // Caller sits #1 after edge E(base); lat = n where done is seen after E(n), -1 on timeout.
  task automatic wait_done(input int base, input int max_cyc, output int lat, output int busy_cyc);
    lat      = -1;
    busy_cyc = busy ? 1 : 0;
    for (int n = base + 1; n <= base + max_cyc; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
      if (busy) busy_cyc++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int lat;
  int bc;
  int done_seen;

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    mode    = 1'b0;
    data_in = '0;
    target  = '0;

    step();
    step();
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_match", match, 0);
    rst = 1'b0;

    // A5 counting ones: 8 shifts + 1 zero-detect cycle.
    launch(8'hA5, 1'b0, 1'b0);
    wait_done(0, 20, lat, bc);
    check("a5_ones_lat", lat, 9);
    check("a5_ones_busy_cycles", bc, 9);
    check("a5_ones_count", count, 4);
    step();
    check("a5_done_pulse_width", done, 0);
    check("a5_count_held", count, 4);

    // A5 counting zeros: sreg=5A, highest bit 6.
    launch(8'hA5, 1'b1, 1'b0);
    wait_done(0, 20, lat, bc);
    check("a5_zeros_lat", lat, 8);
    check("a5_zeros_count", count, 4);

    launch(8'hFF, 1'b1, 1'b0);
    wait_done(0, 20, lat, bc);
    check("ff_zeros_lat", lat, 1);
    check("ff_zeros_count", count, 0);

    launch(8'h00, 1'b0, 1'b0);
    wait_done(0, 20, lat, bc);
    check("zero_in_lat", lat, 1);
    check("zero_in_count", count, 0);

    target = 4'd1;
    launch(8'h01, 1'b0, 1'b0);
    check("one_match_in_shift", match, 0);
    wait_done(0, 20, lat, bc);
    check("one_lat", lat, 2);
    check("one_count", count, 1);
    check("one_match_at_done", match, 0);
    step();
    check("one_match_after_done", match, 1);
    target = 4'd2;
    #1;
    check("one_match_target2", match, 0);

    // Second start during SHIFT must be ignored.
    target = 4'd0;
    launch(8'h80, 1'b0, 1'b0);
    check("busy_match_zero", match, 0);
    @(negedge clk);
    data_in = 8'hFF;
    start   = 1'b1;
    step();
    start = 1'b0;
    wait_done(1, 20, lat, bc);
    check("ignore_lat", lat, 9);
    check("ignore_count", count, 1);
    step();
    check("ignore_no_restart_busy", busy, 0);
    check("ignore_no_restart_done", done, 0);

    // Start held through DONE restarts immediately.
    launch(8'h03, 1'b0, 1'b1);
    wait_done(0, 20, lat, bc);
    check("b2b_first_lat", lat, 3);
    check("b2b_first_count", count, 2);
    step();
    start = 1'b0;
    check("b2b_restart_busy", busy, 1);
    check("b2b_restart_done", done, 0);
    wait_done(0, 20, lat, bc);
    check("b2b_second_lat", lat, 3);
    check("b2b_second_count", count, 2);

    // Reset at E4 aborts without a done pulse.
    launch(8'hFF, 1'b0, 1'b0);
    step();
    step();
    step();
    @(negedge clk);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_count", count, 0);
    check("abort_busy", busy, 0);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) done_seen++;
      step();
    end
    check("abort_no_done", done_seen, 0);

    launch(8'h0F, 1'b0, 1'b0);
    wait_done(0, 20, lat, bc);
    check("post_abort_lat", lat, 5);
    check("post_abort_count", count, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/popcount_seq.md
Name: popcount_seq

Overview:
- Parametrised sequential bit-population counter with an integrated control FSM and a start/busy/done handshake.
- Loads a WIDTH-bit word and shifts it LSB-first, one bit per clock, counting either ones or zeros (runtime mode).
- Terminates early once the remaining shifted word is zero.
- Sits as a self-contained datapath+controller replacing externally sequenced count/shift blocks; the result is held stable for the consumer until the next start.

Parameters:
- WIDTH, 8, input word width (>= 2).
- CNT_W, $clog2(WIDTH+1), width of count result; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  launch request; sampled only in IDLE or DONE.
- mode  in  1  0 = count ones, 1 = count zeros; sampled with start.
- data_in  in  WIDTH  word to count; sampled with start.
- target  in  CNT_W  compare value for the match flag; live, not registered.
- busy  out  1  high while in SHIFT.
- done  out  1  one-cycle pulse when the result becomes valid.
- count  out  CNT_W  result register; holds its value from done until the next accepted start.
- match  out  1  combinational: (count == target) && result_valid.

Behaviour:
- Reset is synchronous and active-high on rst, on the single clock clk.
  - All state clears: state=IDLE, shift register=0, count=0, result_valid=0.
  - Outputs busy=0, done=0, match=0.
  - Reset mid-SHIFT aborts with no done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE
  - start=1: load sreg <= mode ? ~data_in : data_in; count <= 0; result_valid <= 0; go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT (busy=1)
  - If sreg == 0: go to DONE; count unchanged.
  - Else: count <= count + sreg[0] (zero-extended to CNT_W); sreg <= sreg >> 1 (zero fill).
  - start is ignored while in SHIFT.
- DONE
  - done=1 for exactly this cycle; result_valid <= 1.
  - start=1: reload as in IDLE and go to SHIFT (back-to-back restart; done still pulses this cycle).
  - Otherwise go to IDLE.
- Latency, with start sampled at edge E0 and k = index of the highest set bit of the loaded sreg:
  - Shifts occur at E1..E(k+1).
  - Zero detect occurs at E(k+2); done is high in the cycle following E(k+2).
  - Loaded sreg == 0: done follows E1 (1 zero-detect cycle).
  - Worst case is all ones with bit WIDTH-1 set: done follows E(WIDTH+1).
- Width rules
  - count never overflows, since the maximum is WIDTH and fits in CNT_W.
  - The adder is CNT_W wide with carry discarded.
- match is 0 whenever result_valid=0, i.e. after reset and during SHIFT.
- data_in and mode changes after the start cycle have no effect.

Decomposition:
- Package popcount_pkg:
  - typedef enum logic [1:0] state_t {IDLE, SHIFT, DONE}.
  - localparam MODE_ONES=1'b0, MODE_ZEROS=1'b1.
- Sub-module popcount_shreg (WIDTH):
  - Loadable right-shift register with load, shift_en, sync clr.
  - Outputs q, lsb, and is_zero.
- FSM, counter and compare live in popcount_seq.

Test Plan (WIDTH=8):
- Reset: rst=1 for 2 cycles -> count=0, busy=0, done=0, match=0. Then start, data_in=8'hA5, mode=0 -> busy for 9 cycles (8 shifts + 1 zero detect); done pulses after E9; count=4.
- Zeros mode: start, data_in=8'hA5, mode=1 (sreg=8'h5A, k=6) -> count=4; done after E8. Then start, data_in=8'hFF, mode=1 -> count=0; done after E1.
- Zero input, early exit, and match:
  - data_in=8'h00, mode=0 -> done after E1; count=0.
  - data_in=8'h01 -> count=1; done after E2; with target=1, match=1 after done.
  - target=2 -> match=0.
- Start ignored while busy: start with data_in=8'h80, then pulse start with data_in=8'hFF during SHIFT -> count=1; done after E9; no restart.
- Back-to-back restart: start held high through DONE with data_in=8'h03 -> done pulses once with count=2; SHIFT re-entered the next cycle; second done with count=2.
- Reset mid-op: data_in=8'hFF; assert rst at E4 -> no done pulse; count=0, busy=0. Next start with 8'h0F -> count=4.
